// File: rtl/mux8way_stream.sv
// Eight-channel valid/ready gather with round-robin arbitration.
// Ports: clk, rst_n, in_valid[8], in_data[8*W], in_ready[8], out_*.
module mux8way_stream #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_sel;
  logic [2:0]       r_ptr;

  logic             w_load;
  logic             w_found;
  logic             w_take;
  logic [2:0]       w_gnt;
  logic [2:0]       w_idx;
  logic [WIDTH-1:0] w_word;

  assign w_load = !r_valid || out_ready;

  // First requester at or after r_ptr, modulo 8.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = 3'd0;
    w_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_take = w_load && w_found;

  assign w_word =
    in_data[int'(w_gnt)*WIDTH +: WIDTH];

  assign in_ready =
    w_take ? (8'd1 << w_gnt) : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
      r_sel   <= w_gnt;
      r_ptr   <= w_gnt + 3'd1;
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux8way_stream.sv
// Directed-vector bench for mux8way_stream.
// Table vectors plus reset-mid-stream sequence.
module tb_mux8way_stream;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  int n_chk;
  int n_fail;

  mux8way_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  iv;
    logic        ordy;
    logic [15:0] base;
    logic [7:0]  rdy;
    logic        ov;
    logic [15:0] od;
    logic [2:0]  os;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic [7:0]  iv,
    input logic        ordy,
    input logic [15:0] base,
    input logic [7:0]  rdy,
    input logic        ov,
    input logic [15:0] od,
    input logic [2:0]  os
  );
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.base = base;
    v.rdy = rdy; v.ov = ov; v.od = od; v.os = os;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic [7:0]  iv,
    input logic        ordy,
    input logic [15:0] base
  );
    in_valid  = iv;
    out_ready = ordy;
    for (int c = 0; c < 8; c++)
      in_data[c*W +: W] = base + 16'(c);
  endtask

  task automatic step(input vec_t v, input int n);
    string t;
    @(negedge clk);
    drive(v.iv, v.ordy, v.base);
    #1;
    t = $sformatf("v%0d", n);
    chk({t, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk({t, ".out_valid"}, 32'(out_valid), 32'(v.ov));
    chk({t, ".out_data"}, 32'(out_data), 32'(v.od));
    chk({t, ".out_sel"}, 32'(out_sel), 32'(v.os));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(8'h00, 1'b0, 16'h0000);

    // Round robin from ch0, ch i data = 0x1000+i.
    for (int k = 0; k < 10; k++)
      vt.push_back(mk(8'hFF, 1'b1, 16'h1000,
                      8'd1 << (k % 8), 1'b1,
                      16'h1000 + 16'(k % 8),
                      3'(k % 8)));
    // ptr=2: single channel 3.
    vt.push_back(mk(8'h08, 1, 16'hBEEC,
                    8'h08, 1, 16'hBEEF, 3'd3));
    // Idle drain: hold data/sel, ptr stays 4.
    vt.push_back(mk(8'h00, 1, 16'h0000,
                    8'h00, 0, 16'hBEEF, 3'd3));
    vt.push_back(mk(8'hFF, 1, 16'h1000,
                    8'h10, 1, 16'h1004, 3'd4));
    vt.push_back(mk(8'hFF, 1, 16'h0050,
                    8'h20, 1, 16'h0055, 3'd5));
    // Backpressure 4 cycles.
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(8'h21, 0, 16'h0050,
                      8'h00, 1, 16'h0055, 3'd5));
    // Release: ptr=6 wraps to ch0.
    vt.push_back(mk(8'h21, 1, 16'h0050,
                    8'h01, 1, 16'h0050, 3'd0));
    // ptr=1 -> ch6.
    vt.push_back(mk(8'h40, 1, 16'h2000,
                    8'h40, 1, 16'h2006, 3'd6));
    // Scan from 7 wraps to ch1, then ch6.
    vt.push_back(mk(8'h42, 1, 16'h2000,
                    8'h02, 1, 16'h2001, 3'd1));
    vt.push_back(mk(8'h42, 1, 16'h2000,
                    8'h40, 1, 16'h2006, 3'd6));
    vt.push_back(mk(8'h00, 1, 16'h0000,
                    8'h00, 0, 16'h2006, 3'd6));
    // ptr=7: ch2 loads 0x1234, then stalls.
    vt.push_back(mk(8'h04, 0, 16'h1232,
                    8'h04, 1, 16'h1234, 3'd2));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_sel", 32'(out_sel), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      step(vt[i], i);

    // Asynchronous reset between edges.
    @(negedge clk);
    drive(8'h00, 1'b0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data", 32'(out_data), 32'd0);
    chk("arst.out_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan restarts at ch0 ahead of ch7.
    step(mk(8'h81, 1, 16'h0A00,
            8'h01, 1, 16'h0A00, 3'd0), 100);
    step(mk(8'h80, 1, 16'h0A00,
            8'h80, 1, 16'h0A07, 3'd7), 101);
    step(mk(8'h00, 1, 16'h0000,
            8'h00, 0, 16'h0A07, 3'd7), 102);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8way_stream.md
# mux8way_stream

Eight-to-one streaming gather block, the return path to the 8-way demultiplexer: the demux scatters one input to one of eight destinations, and this block collects eight valid/ready source channels onto one output. A fair round-robin arbiter selects the source, and the winning word is captured into a single registered output stage tagged with its channel index. It sits between the eight RAM8/register-bank read sources and the shared data bus into the CPU/ALU side.

## Interface
Parameters:
- WIDTH, 16, data width per channel (Hack word).

Ports (`clk` single clock; `rst_n` asynchronous, active-low):
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  8  per-channel request; bit i = channel i has a word.
- in_data  input  8*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  8  per-channel accept; one-hot or zero; combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  3  registered index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.

## Operation
- Transfer on input channel i: in_valid[i] && in_ready[i] at a rising edge. Transfer on output: out_valid && out_ready at a rising edge.
- load = !out_valid || out_ready. The output register can take a new word this cycle.
- Arbitration: a 3-bit pointer ptr. Scan channels ptr, ptr+1, … ptr+7 (mod 8). The first with in_valid set wins (grant).
- in_ready = one-hot(grant) when load && |in_valid, else 8'b0. in_ready[i] is never asserted while in_valid[i] is low.
- On a granted transfer of channel g:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= g+1 mod 8 (7 wraps to 0)
- On load with no in_valid:
  - out_valid <= 0 (if currently draining)
  - out_data and out_sel hold their last values
  - ptr unchanged
- While out_valid && !out_ready:
  - out_data and out_sel are stable
  - in_ready = 0
  - ptr unchanged
- Fairness: with all 8 requesting continuously and out_ready=1, grants cycle 0,1,2,…,7,0. No channel waits more than 7 grants after asserting in_valid.
- Sources must hold in_valid/in_data until accepted. The block tolerates withdrawal: it only arbitrates on the current cycle's in_valid.

## Timing
- Reset (rst_n low, asynchronous, any time): out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0 is implied. Any word held in the output register is discarded.
- Reset release: the first grant scan starts at channel 0.
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Throughput: one word per cycle when out_ready is held high. Simultaneous drain and refill in the same cycle is supported, with no bubble.
- Combinational paths:
  - out_ready → in_ready
  - in_valid → in_ready
- No combinational path from in_data to any output. No combinational path to out_valid.

## Test plan
- Reset mid-stream:
  - Stimulus: out_valid=1, out_data=0x1234; assert rst_n=0 between clock edges.
  - Response: out_valid, out_data, out_sel go to 0 immediately, without a clock edge.
  - After release, with in_valid=8'h80 and 8'h01 both pending, channel 0 is granted first.
- Single channel:
  - Stimulus: in_valid=8'h08, in_data ch3=0xBEEF, out_ready=1.
  - Response: in_ready=8'h08. Next cycle out_valid=1, out_data=0xBEEF, out_sel=3.
- Full round-robin:
  - Stimulus: in_valid=8'hFF, channel i data=0x1000+i, out_ready=1 for 10 cycles.
  - Response: out_sel sequence 0,1,…,7,0,1 on consecutive cycles, and out_data matches.
- Backpressure:
  - Stimulus: output holds ch5 word 0x0055; out_ready=0 for 4 cycles with in_valid=8'h21.
  - Response: in_ready=0, and out_data/out_sel stable at 0x0055/5.
  - Then out_ready=1: same-cycle refill with ch0 (ptr=6 wraps), out_sel=0 next cycle.
- Pointer wrap and skip:
  - Stimulus: last grant was 6; in_valid=8'h42 (ch1, ch6).
  - Response: scan starts at 7 and wraps; grant ch1 (in_ready=8'h02). Next grant is ch6.
- Idle drain:
  - Stimulus: out_valid=1, out_ready=1, in_valid=0.
  - Response: next cycle out_valid=0, out_data/out_sel unchanged, ptr unchanged.
